// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: divisor configuration bus for clk_div_prog
//  cfg_we   write strobe for a new divisor
//  cfg_ch   channel the write targets
//  cfg_div  new divisor N (0 and 1 are clamped to 2 by the divider)
//  cfg_pend per-channel flag, 1 while a written divisor is not yet active
interface clk_div_prog_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 26
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] cfg_pend;
  modport master (output cfg_we, cfg_ch, cfg_div, input cfg_pend);
  modport slave  (input cfg_we, cfg_ch, cfg_div, output cfg_pend);
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock divider with glitch-free divisor updates
//  clk, rst     system clock, asynchronous active-high reset
//  en_i         per-channel run enable
//  sync_clr_i   phase clear of every channel
//  cfg          divisor write bus (slave side), reports pending divisors
//  clk_out_o    registered divided clocks, low floor(N/2) then high for the rest
//  tick_o       one-cycle pulse coincident with each clk_out_o rise
module clk_div_prog #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 26,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {26'd50_000_000, 26'd50_000, 26'd5}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_clr_i,
  clk_div_prog_if.slave     cfg,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic [NUM_CH-1:0] tick_o
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] pend_v;
  assign cfg.cfg_pend = pend_v;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d, nxt, half;
    logic clk_q, clk_d, tick_q, tick_d, wrap, run, wr;
    assign half = act_q >> 1;
    assign wrap = cnt_q == act_q - CNT_W'(1);
    assign wr   = cfg.cfg_we && cfg.cfg_ch == CH_W'(c);
    assign run  = en_i[c] && !sync_clr_i;
    always_comb begin
      nxt    = wrap ? '0 : cnt_q + CNT_W'(1);
      pend_d = wr ? (cfg.cfg_div < CNT_W'(2) ? CNT_W'(2) : cfg.cfg_div) : pend_q;
      cnt_d  = run ? nxt : '0;
      clk_d  = run && nxt >= half;
      tick_d = run && nxt == half;
      // a stopped or cleared channel adopts the pending divisor immediately;
      // a running one only at wrap, reading the old pend_q so a same-edge write waits a period
      act_d  = (!run || wrap) ? pend_q : act_q;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        act_q  <= DIV_INIT[c*CNT_W +: CNT_W];
        pend_q <= DIV_INIT[c*CNT_W +: CNT_W];
      end else begin
        cnt_q  <= cnt_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
        act_q  <= act_d;
        pend_q <= pend_d;
      end
    assign clk_out_o[c] = clk_q;
    assign tick_o[c]    = tick_q;
    assign pend_v[c]    = pend_q != act_q;
  end
endmodule
